vector_minmax_pipe: RTL

VECTOR_MINMAX_PIPE -- requirements
Module: vector_minmax_pipe

---
 rtl/vector_minmax_pipe.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vector_minmax_pipe.sv
// Pipelined vector min/max (signed/unsigned, SEW 8..64) with valid/ready flow control.
// Optional reduction mode (redop port, one extra latency stage) when VMINMAX_REDUCTION_EN is defined.
module vector_minmax_pipe #(
    parameter int VLEN   = 128,
    parameter int STAGES = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [1:0]      sew,
`ifdef VMINMAX_REDUCTION_EN
    input  logic            redop,
`endif
    input  logic [VLEN-1:0] vs2,
    input  logic [VLEN-1:0] vs1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [VLEN-1:0] vd
);

`ifdef VMINMAX_REDUCTION_EN
    localparam int LAT = STAGES + 1;
`else
    localparam int LAT = STAGES;
`endif
    // One operand-capture stage when LAT >= 2, the rest carry results; vd is the last result stage.
    localparam int NR = (LAT >= 2) ? LAT - 1 : 1;

    // Returns a (vs2 element) or b (vs1 element); b wins only on a strict compare, so ties give a.
    function automatic logic [63:0] elem_pick(input logic [1:0] f, input logic [63:0] a,
                                              input logic [63:0] b, input int w);
        logic [63:0] m, ea, eb;
        logic [64:0] ka, kb;
        logic        b_wins;
        m  = ~64'd0 << w;
        ea = (f[0] && a[w-1]) ? (a | m) : a;
        eb = (f[0] && b[w-1]) ? (b | m) : b;
        ka = {f[0] & ea[63], ea};
        kb = {f[0] & eb[63], eb};
        b_wins = f[1] ? ($signed(kb) > $signed(ka)) : ($signed(kb) < $signed(ka));
        return b_wins ? b : a;
    endfunction

    function automatic logic [VLEN-1:0] elementwise(input logic [1:0] f, input logic [1:0] s,
                                                    input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
        logic [VLEN-1:0] r;
        logic [63:0]     t;
        r = '0;
        t = '0;
        case (s)
            2'b00: for (int i = 0; i < VLEN/8; i++) begin
                t = elem_pick(f, 64'(a[i*8 +: 8]), 64'(b[i*8 +: 8]), 8);
                r[i*8 +: 8] = t[7:0];
            end
            2'b01: for (int i = 0; i < VLEN/16; i++) begin
                t = elem_pick(f, 64'(a[i*16 +: 16]), 64'(b[i*16 +: 16]), 16);
                r[i*16 +: 16] = t[15:0];
            end
            2'b10: for (int i = 0; i < VLEN/32; i++) begin
                t = elem_pick(f, 64'(a[i*32 +: 32]), 64'(b[i*32 +: 32]), 32);
                r[i*32 +: 32] = t[31:0];
            end
            default: for (int i = 0; i < VLEN/64; i++) begin
                r[i*64 +: 64] = elem_pick(f, a[i*64 +: 64], b[i*64 +: 64], 64);
            end
        endcase
        return r;
    endfunction

`ifdef VMINMAX_REDUCTION_EN
    // Folds every vs2 element into vs1 element 0; upper result elements stay zero.
    function automatic logic [VLEN-1:0] reduce(input logic [1:0] f, input logic [1:0] s,
                                               input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
        logic [VLEN-1:0] r;
        logic [63:0]     acc;
        r = '0;
        case (s)
            2'b00: begin
                acc = 64'(b[7:0]);
                for (int i = 0; i < VLEN/8; i++) acc = elem_pick(f, acc, 64'(a[i*8 +: 8]), 8);
                r[7:0] = acc[7:0];
            end
            2'b01: begin
                acc = 64'(b[15:0]);
                for (int i = 0; i < VLEN/16; i++) acc = elem_pick(f, acc, 64'(a[i*16 +: 16]), 16);
                r[15:0] = acc[15:0];
            end
            2'b10: begin
                acc = 64'(b[31:0]);
                for (int i = 0; i < VLEN/32; i++) acc = elem_pick(f, acc, 64'(a[i*32 +: 32]), 32);
                r[31:0] = acc[31:0];
            end
            default: begin
                acc = b[63:0];
                for (int i = 0; i < VLEN/64; i++) acc = elem_pick(f, acc, a[i*64 +: 64], 64);
                r[63:0] = acc;
            end
        endcase
        return r;
    endfunction
`endif

    // Handshake: a transfer occurs on a rising edge where valid and ready are both 1; the whole
    // pipeline advances together whenever the output register is empty or being drained.
    logic adv;
    assign in_ready = !out_valid || out_ready;
    assign adv      = in_ready;

    logic            src_valid;
    logic [1:0]      src_op, src_sew;
    logic [VLEN-1:0] src_a, src_b;
`ifdef VMINMAX_REDUCTION_EN
    logic            src_red;
`endif

    generate
        if (LAT >= 2) begin : g_cap
            logic            cap_v;
            logic [1:0]      cap_op, cap_sew;
            logic [VLEN-1:0] cap_a, cap_b;
`ifdef VMINMAX_REDUCTION_EN
            logic            cap_red;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)               cap_red <= 1'b0;
                else if (adv && in_valid)   cap_red <= redop;
            end
            assign src_red = cap_red;
`endif
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    cap_v   <= 1'b0;
                    cap_op  <= '0;
                    cap_sew <= '0;
                    cap_a   <= '0;
                    cap_b   <= '0;
                end else if (adv) begin
                    cap_v <= in_valid;
                    if (in_valid) begin
                        cap_op  <= op;
                        cap_sew <= sew;
                        cap_a   <= vs2;
                        cap_b   <= vs1;
                    end
                end
            end
            assign src_valid = cap_v;
            assign src_op    = cap_op;
            assign src_sew   = cap_sew;
            assign src_a     = cap_a;
            assign src_b     = cap_b;
        end else begin : g_nocap
            assign src_valid = in_valid;
            assign src_op    = op;
            assign src_sew   = sew;
            assign src_a     = vs2;
            assign src_b     = vs1;
`ifdef VMINMAX_REDUCTION_EN
            assign src_red   = redop;
`endif
        end
    endgenerate

    logic [VLEN-1:0] res;
`ifdef VMINMAX_REDUCTION_EN
    assign res = src_red ? reduce(src_op, src_sew, src_a, src_b)
                         : elementwise(src_op, src_sew, src_a, src_b);
`else
    assign res = elementwise(src_op, src_sew, src_a, src_b);
`endif

    // Result stages load data only behind a valid entry, so bubbles leave vd untouched.
    logic [NR-1:0]   rv_q;
    logic [VLEN-1:0] rd_q [NR];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rv_q <= '0;
            for (int k = 0; k < NR; k++) rd_q[k] <= '0;
        end else if (adv) begin
            rv_q[0] <= src_valid;
            if (src_valid) rd_q[0] <= res;
            for (int k = 1; k < NR; k++) begin
                rv_q[k] <= rv_q[k-1];
                if (rv_q[k-1]) rd_q[k] <= rd_q[k-1];
            end
        end
    end

    assign out_valid = rv_q[NR-1];
    assign vd        = rd_q[NR-1];

endmodule
